max7219_refresh_sequencer: RTL and testbench

//  Sequences all traffic to the 2x2 chain of MAX7219 8x8 matrices that shows the 16x16 snake grid.
//  - After reset, issues the init command list.
//  - On each frame_tick, snapshots the grid and refreshes digits 1..8 on every device.
//  - Inserts intensity updates between rows.

---
 rtl/max7219_pkg.sv | 58 +++++
 rtl/max7219_row_pack.sv | 22 ++
 rtl/max7219_refresh_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_max7219_refresh_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/max7219_pkg.sv
// Register map, init command list and sequencer state type for the 2x2 MAX7219 chain
// that shows the 16x16 snake grid.
package max7219_pkg;

  localparam logic [7:0] ADDR_DIGIT0     = 8'h01;
  localparam logic [7:0] ADDR_DIGIT1     = 8'h02;
  localparam logic [7:0] ADDR_DIGIT2     = 8'h03;
  localparam logic [7:0] ADDR_DIGIT3     = 8'h04;
  localparam logic [7:0] ADDR_DIGIT4     = 8'h05;
  localparam logic [7:0] ADDR_DIGIT5     = 8'h06;
  localparam logic [7:0] ADDR_DIGIT6     = 8'h07;
  localparam logic [7:0] ADDR_DIGIT7     = 8'h08;
  localparam logic [7:0] ADDR_DECODE     = 8'h09;
  localparam logic [7:0] ADDR_INTENSITY  = 8'h0A;
  localparam logic [7:0] ADDR_SCAN_LIMIT = 8'h0B;
  localparam logic [7:0] ADDR_SHUTDOWN   = 8'h0C;
  localparam logic [7:0] ADDR_DISP_TEST  = 8'h0F;

  localparam int NUM_INIT = 6;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ROWS,
    ST_BRIGHT,
    ST_FDONE
  } seq_state_e;

  // Init list: shut down, test off, raw mode, scan all 8 digits, intensity, wake up.
  function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] intensity);
    logic [15:0] w;
    case (idx)
      3'd0:    w = {ADDR_SHUTDOWN, 8'h00};
      3'd1:    w = {ADDR_DISP_TEST, 8'h00};
      3'd2:    w = {ADDR_DECODE, 8'h00};
      3'd3:    w = {ADDR_SCAN_LIMIT, 8'h07};
      3'd4:    w = {ADDR_INTENSITY, 4'h0, intensity};
      default: w = {ADDR_SHUTDOWN, 8'h01};
    endcase
    return w;
  endfunction

  function automatic logic [7:0] digit_addr(input logic [2:0] row);
    logic [7:0] a;
    case (row)
      3'd0:    a = ADDR_DIGIT0;
      3'd1:    a = ADDR_DIGIT1;
      3'd2:    a = ADDR_DIGIT2;
      3'd3:    a = ADDR_DIGIT3;
      3'd4:    a = ADDR_DIGIT4;
      3'd5:    a = ADDR_DIGIT5;
      3'd6:    a = ADDR_DIGIT6;
      default: a = ADDR_DIGIT7;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/max7219_row_pack.sv
// Picks one digit row out of the shadow grid for every device of the 2x2 chain.
// Device d owns rows 8*(d/2)+r and cols 8*(d%2)+c; column c lands on data bit 7-c.
module max7219_row_pack #(
  parameter int NUM_DEV = 4
) (
  input  logic [15:0][15:0]       shadow_i,
  input  logic [2:0]              row_i,
  output logic [NUM_DEV-1:0][7:0] bytes_o
);

  genvar gi, gj;
  for (gi = 0; gi < NUM_DEV; gi++) begin : g_dev
    localparam int ROW_BASE = 8 * (gi / 2);
    localparam int COL_BASE = 8 * (gi % 2);
    logic [3:0] row_idx;
    assign row_idx = 4'(ROW_BASE) + {1'b0, row_i};
    for (gj = 0; gj < 8; gj++) begin : g_col
      assign bytes_o[gi][7-gj] = shadow_i[row_idx][COL_BASE+gj];
    end
  end

endmodule

// File: rtl/max7219_refresh_sequencer.sv
// Generates every chain-wide MAX7219 transaction: init list, per-frame digit refresh
// from a grid snapshot, and intensity updates slotted in between rows.
module max7219_refresh_sequencer
  import max7219_pkg::*;
#(
  parameter int         NUM_DEV       = 4,
  parameter logic [3:0] INTENSITY_RST = 4'hF,
  parameter int         REINIT_FRAMES = 0
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [15:0][15:0]      grid_i,
  input  logic                   frame_tick_i,
  input  logic                   bright_req_i,
  input  logic [3:0]             bright_val_i,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  output logic [16*NUM_DEV-1:0]  tx_data_o,
  output logic                   init_done_o,
  output logic                   frame_done_o,
  output logic                   overrun_o
);

  seq_state_e             state_q, state_d;
  logic [2:0]             cmd_idx_q, cmd_idx_d;
  logic [2:0]             row_q, row_d;
  logic [15:0][15:0]      shadow_q, shadow_d;
  logic [3:0]             intensity_q, intensity_d;
  logic                   pend_frame_q, pend_frame_d;
  logic                   pend_bright_q, pend_bright_d;
  logic                   standalone_q, standalone_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic                   init_done_q, init_done_d;
  logic                   overrun_q, overrun_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [16*NUM_DEV-1:0]  tx_data_q, tx_data_d;

  logic [NUM_DEV-1:0][7:0] row_bytes;
  logic [16*NUM_DEV-1:0]   word_bus;
  logic [7:0]              word_addr, word_byte;
  logic                    use_rows, have_word, accept;

  max7219_row_pack #(.NUM_DEV(NUM_DEV)) u_row_pack (
    .shadow_i (shadow_q),
    .row_i    (row_q),
    .bytes_o  (row_bytes)
  );

  // A new bright_val is visible to a word loaded in the same cycle.
  assign intensity_d = bright_req_i ? bright_val_i : intensity_q;
  assign accept      = tx_valid_q & tx_ready_i;

  always_comb begin
    word_addr = 8'h00;
    word_byte = 8'h00;
    use_rows  = 1'b0;
    have_word = 1'b0;
    case (state_q)
      ST_INIT: begin
        have_word              = 1'b1;
        {word_addr, word_byte} = init_word(cmd_idx_q, intensity_d);
      end
      ST_ROWS: begin
        have_word = 1'b1;
        use_rows  = 1'b1;
        word_addr = digit_addr(row_q);
      end
      ST_BRIGHT: begin
        have_word = 1'b1;
        word_addr = ADDR_INTENSITY;
        word_byte = {4'h0, intensity_d};
      end
      default: ;
    endcase
  end

  genvar gi;
  for (gi = 0; gi < NUM_DEV; gi++) begin : g_word
    assign word_bus[16*gi +: 16] = {word_addr, use_rows ? row_bytes[gi] : word_byte};
  end

  always_comb begin
    state_d       = state_q;
    cmd_idx_d     = cmd_idx_q;
    row_d         = row_q;
    shadow_d      = shadow_q;
    pend_frame_d  = pend_frame_q;
    pend_bright_d = pend_bright_q;
    standalone_d  = standalone_q;
    frame_cnt_d   = frame_cnt_q;
    init_done_d   = init_done_q;
    overrun_d     = overrun_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;

    if (bright_req_i && state_q != ST_INIT) pend_bright_d = 1'b1;
    if (frame_tick_i && state_q != ST_IDLE) begin
      if (pend_frame_q) overrun_d = 1'b1;
      else              pend_frame_d = 1'b1;
    end

    case (state_q)
      ST_INIT: begin
        if (accept) begin
          if (cmd_idx_q == 3'(NUM_INIT - 1)) begin
            cmd_idx_d   = 3'd0;
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            cmd_idx_d = cmd_idx_q + 3'd1;
          end
        end
      end
      ST_IDLE: begin
        if (frame_tick_i || pend_frame_q) begin
          shadow_d     = grid_i;
          pend_frame_d = 1'b0;
          row_d        = 3'd0;
          state_d      = ST_ROWS;
        end else if (pend_bright_q) begin
          standalone_d = 1'b1;
          state_d      = ST_BRIGHT;
        end
      end
      ST_ROWS: begin
        if (accept) begin
          if (pend_bright_q)       state_d = ST_BRIGHT;
          else if (row_q == 3'd7)  state_d = ST_FDONE;
          else                     row_d   = row_q + 3'd1;
        end
      end
      ST_BRIGHT: begin
        if (!tx_valid_q) pend_bright_d = 1'b0;
        if (accept) begin
          if (standalone_q) begin
            standalone_d = 1'b0;
            state_d      = ST_IDLE;
          end else if (row_q == 3'd7) begin
            state_d = ST_FDONE;
          end else begin
            row_d   = row_q + 3'd1;
            state_d = ST_ROWS;
          end
        end
      end
      ST_FDONE: begin
        if (REINIT_FRAMES != 0 && frame_cnt_q == 16'(REINIT_FRAMES - 1)) begin
          frame_cnt_d = '0;
          cmd_idx_d   = 3'd0;
          state_d     = ST_INIT;
        end else begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // Load only into an empty slot so a presented word never changes before acceptance.
    if (have_word && !tx_valid_q) begin
      tx_valid_d = 1'b1;
      tx_data_d  = word_bus;
    end else if (accept) begin
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q       <= ST_INIT;
      cmd_idx_q     <= 3'd0;
      row_q         <= 3'd0;
      shadow_q      <= '0;
      intensity_q   <= INTENSITY_RST;
      pend_frame_q  <= 1'b0;
      pend_bright_q <= 1'b0;
      standalone_q  <= 1'b0;
      frame_cnt_q   <= '0;
      init_done_q   <= 1'b0;
      overrun_q     <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      cmd_idx_q     <= cmd_idx_d;
      row_q         <= row_d;
      shadow_q      <= shadow_d;
      intensity_q   <= intensity_d;
      pend_frame_q  <= pend_frame_d;
      pend_bright_q <= pend_bright_d;
      standalone_q  <= standalone_d;
      frame_cnt_q   <= frame_cnt_d;
      init_done_q   <= init_done_d;
      overrun_q     <= overrun_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
    end
  end

  assign tx_valid_o   = tx_valid_q;
  assign tx_data_o    = tx_data_q;
  assign init_done_o  = init_done_q;
  assign frame_done_o = (state_q == ST_FDONE);
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_max7219_refresh_sequencer.sv
// Directed and randomized checks of the MAX7219 refresh sequencer against a
// transaction-level model of the expected word stream.
module tb_max7219_refresh_sequencer;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [15:0][15:0] grid;
  logic              frame_tick, bright_req;
  logic [3:0]        bright_val;
  logic              tx_valid, tx_ready;
  logic [63:0]       tx_data;
  logic              init_done, frame_done, overrun;

  int total = 0;
  int bad = 0;
  int fd_count = 0;

  logic [15:0] init_list [6] = '{16'h0C00, 16'h0F00, 16'h0900, 16'h0B07, 16'h0A0F, 16'h0C01};

  always #5 clk = ~clk;

  max7219_refresh_sequencer dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .grid_i       (grid),
    .frame_tick_i (frame_tick),
    .bright_req_i (bright_req),
    .bright_val_i (bright_val),
    .tx_valid_o   (tx_valid),
    .tx_ready_i   (tx_ready),
    .tx_data_o    (tx_data),
    .init_done_o  (init_done),
    .frame_done_o (frame_done),
    .overrun_o    (overrun)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rep(input logic [15:0] w);
    return {4{w}};
  endfunction

  // Device d shows rows 8*(d/2)+r, cols 8*(d%2)+c, with column c on data bit 7-c.
  function automatic logic [63:0] row_exp(input logic [15:0][15:0] g, input int r);
    logic [63:0] v;
    logic [7:0]  b;
    v = '0;
    for (int d = 0; d < 4; d++) begin
      b = '0;
      for (int c = 0; c < 8; c++) b[7-c] = g[8*(d/2)+r][8*(d%2)+c];
      v[16*d +: 16] = {8'(r + 1), b};
    end
    return v;
  endfunction

  // One clock: drive ready, note acceptance, then sample at the falling edge.
  task automatic cyc(input logic rdy, output logic acc, output logic [63:0] word);
    logic        hold;
    logic [63:0] held;
    tx_ready = rdy;
    acc  = (tx_valid === 1'b1) && rdy && (reset_n === 1'b1);
    word = tx_data;
    hold = (reset_n === 1'b1) && (tx_valid === 1'b1) && !rdy;
    held = tx_data;
    @(negedge clk);
    if (hold) begin
      check("hold_valid", 64'(tx_valid), 64'd1);
      check("hold_data", tx_data, held);
    end
    if (frame_done === 1'b1) fd_count++;
    frame_tick = 1'b0;
    bright_req = 1'b0;
  endtask

  task automatic idle(input int n);
    logic acc;
    logic [63:0] wd;
    for (int i = 0; i < n; i++) cyc(1'b1, acc, wd);
  endtask

  task automatic next_txn(input bit rnd, output logic [63:0] w);
    logic acc;
    logic [63:0] wd;
    bit got;
    got = 0;
    w = 'x;
    for (int i = 0; i < 200 && !got; i++) begin
      cyc(rnd ? 1'($urandom_range(0, 1)) : 1'b1, acc, wd);
      if (acc) begin
        got = 1;
        w = wd;
      end
    end
    total++;
    assert (got) else begin
      bad++;
      $error("FAIL txn_timeout observed=none expected=accepted_word");
    end
  endtask

  task automatic wait_valid();
    logic acc;
    logic [63:0] wd;
    for (int i = 0; i < 50 && tx_valid !== 1'b1; i++) cyc(1'b0, acc, wd);
    check("wait_valid", 64'(tx_valid), 64'd1);
  endtask

  task automatic run_init(input string tag);
    logic [63:0] w;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) check({tag, "_init_done_early"}, 64'(init_done), 64'd0);
      next_txn(0, w);
      check($sformatf("%s_word%0d", tag, i), w, rep(init_list[i]));
    end
    check({tag, "_init_done"}, 64'(init_done), 64'd1);
  endtask

  task automatic rows(input logic [15:0][15:0] g, input string tag, input bit rnd, input bit scramble);
    logic [63:0] w;
    for (int r = 0; r < 8; r++) begin
      next_txn(rnd, w);
      check($sformatf("%s_row%0d", tag, r), w, row_exp(g, r));
      if (scramble) for (int k = 0; k < 16; k++) grid[k] = 16'($urandom);
    end
  endtask

  function automatic logic [15:0][15:0] rand_grid();
    logic [15:0][15:0] g;
    for (int k = 0; k < 16; k++) g[k] = 16'($urandom);
    return g;
  endfunction

  initial begin
    logic [63:0]       w, wd;
    logic              acc;
    logic [15:0][15:0] g1, g2;
    logic [3:0]        v;

    reset_n = 1'b0; tx_ready = 1'b0; frame_tick = 1'b0; bright_req = 1'b0;
    bright_val = 4'h0; grid = '0;
    for (int i = 0; i < 3; i++) cyc(1'b0, acc, wd);
    check("rst_valid", 64'(tx_valid), 64'd0);
    check("rst_data", tx_data, 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    reset_n = 1'b1;

    // Init list replicated on all four devices.
    run_init("t1");

    // Corner pixels of the grid.
    grid = '0;
    grid[0]  = 16'h8001;
    grid[15] = 16'hFFFF;
    g1 = grid;
    fd_count = 0;
    frame_tick = 1'b1;
    for (int r = 0; r < 8; r++) begin
      next_txn(0, w);
      check($sformatf("t2_row%0d", r), w, row_exp(g1, r));
      if (r == 0) begin
        check("t2_d1_dev0", 64'(w[15:0]), 64'h0180);
        check("t2_d1_dev1", 64'(w[31:16]), 64'h0101);
      end
      if (r == 7) begin
        check("t2_d8_dev2", 64'(w[47:32]), 64'h08FF);
        check("t2_d8_dev3", 64'(w[63:48]), 64'h08FF);
      end
    end
    idle(4);
    check("t2_frame_done", 64'(fd_count), 64'd1);
    check("t2_idle", 64'(tx_valid), 64'd0);

    // Random ready with grid churn, then a tick landing on frame_done.
    g1 = rand_grid();
    grid = g1;
    frame_tick = 1'b1;
    rows(g1, "t3a", 1, 1);
    check("t3_fdone_now", 64'(frame_done), 64'd1);
    g2 = rand_grid();
    grid = g2;
    frame_tick = 1'b1;
    rows(g2, "t3b", 1, 0);
    idle(4);

    // Intensity update requested while row 2 is on the bus.
    g1 = rand_grid();
    grid = g1;
    frame_tick = 1'b1;
    for (int r = 0; r < 2; r++) begin
      next_txn(0, w);
      check($sformatf("t4_row%0d", r), w, row_exp(g1, r));
    end
    wait_valid();
    bright_req = 1'b1;
    bright_val = 4'h3;
    cyc(1'b0, acc, wd);
    next_txn(0, w);
    check("t4_row2", w, row_exp(g1, 2));
    next_txn(0, w);
    check("t4_bright", w, rep(16'h0A03));
    for (int r = 3; r < 8; r++) begin
      next_txn(1, w);
      check($sformatf("t4_row%0d", r), w, row_exp(g1, r));
    end
    idle(4);

    // Standalone intensity update from idle.
    v = 4'($urandom);
    bright_req = 1'b1;
    bright_val = v;
    next_txn(1, w);
    check("t4_standalone", w, rep({8'h0A, 4'h0, v}));
    idle(6);
    check("t4_back_idle", 64'(tx_valid), 64'd0);

    // Three ticks inside one frame: one extra frame, sticky overrun.
    check("t5_overrun_pre", 64'(overrun), 64'd0);
    fd_count = 0;
    g1 = rand_grid();
    grid = g1;
    frame_tick = 1'b1;
    next_txn(0, w);
    check("t5a_row0", w, row_exp(g1, 0));
    g2 = rand_grid();
    grid = g2;
    for (int r = 1; r < 8; r++) begin
      if (r <= 3) begin
        frame_tick = 1'b1;
        cyc(1'b0, acc, wd);
      end
      if (r == 3) check("t5_overrun", 64'(overrun), 64'd1);
      next_txn(0, w);
      check($sformatf("t5a_row%0d", r), w, row_exp(g1, r));
    end
    rows(g2, "t5b", 1, 0);
    idle(10);
    check("t5_frames", 64'(fd_count), 64'd2);
    check("t5_no_more", 64'(tx_valid), 64'd0);
    check("t5_overrun_sticky", 64'(overrun), 64'd1);

    // Reset while row 5 is presented.
    g1 = rand_grid();
    grid = g1;
    frame_tick = 1'b1;
    for (int r = 0; r < 5; r++) begin
      next_txn(0, w);
      check($sformatf("t6_row%0d", r), w, row_exp(g1, r));
    end
    wait_valid();
    reset_n = 1'b0;
    cyc(1'b0, acc, wd);
    check("t6_valid_drop", 64'(tx_valid), 64'd0);
    check("t6_data_clr", tx_data, 64'd0);
    check("t6_init_done_clr", 64'(init_done), 64'd0);
    check("t6_overrun_clr", 64'(overrun), 64'd0);
    reset_n = 1'b1;
    run_init("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
